div_check_serial: RTL and testbench
===================================

# div_check_serial

Parametrised, sequential divisibility checker: the successor to our fixed 5-bit combinational divisible-by-(2..9) selector. It accepts a `WIDTH`-bit dividend and a runtime `DIV_W`-bit divisor and computes the remainder bit-serially, MSB first, one bit per clock. It reports `DIVISIBLE`, `REM` and a divide-by-zero `ERR` under a START/BUSY/DONE handshake. It sits beside the arithmetic test blocks and is driven by a controller FSM or testbench.

## Interface
- `WIDTH`, default 5: dividend width in bits, ≥ 1.
- `DIV_W`, default 4: divisor and remainder width in bits, ≥ 2.
- `CLK`  input  1: sole clock; all state updates on the rising edge.
- `RST`  input  1: asynchronous, active-high reset.
- `START`  input  1: request; sampled only when the block is idle or done.
- `A`  input  WIDTH: dividend; captured on an accepted START.
- `DIV`  input  DIV_W: divisor; captured on an accepted START.
- `BUSY`  output  1: high while in RUN.
- `DONE`  output  1: one-cycle pulse; results valid from this cycle onward.
- `DIVISIBLE`  output  1: 1 iff `DIV` ≠ 0 and `A mod DIV` = 0.
- `REM`  output  DIV_W: `A mod DIV`; 0 when `ERR` is 1.
- `ERR`  output  1: 1 iff the captured `DIV` was 0.

## Operation
- States: IDLE, RUN, DONE. Internal registers:
  - `a_q` [WIDTH], `d_q` [DIV_W]: captured operands.
  - `r_q` [DIV_W]: running residue.
  - `cnt` [clog2(WIDTH+1)]: bit counter.
- Accept condition: START=1 while state is IDLE or DONE.
- On accept with `DIV` ≠ 0:
  - Capture `A` and `DIV`, set `r_q`=0 and `cnt`=0, go to RUN.
- On accept with `DIV` = 0:
  - Go directly to DONE with `ERR`=1, `DIVISIBLE`=0, `REM`=0.
- START while in RUN is ignored; operands and progress are unaffected.
- RUN, each edge:
  - Let b = `a_q[WIDTH-1-cnt]` and t = 2·`r_q` + b, computed at DIV_W+1 bits.
  - `r_q` ← (t ≥ `d_q`) ? t − `d_q` : t.
  - Invariant: `r_q` < `d_q`, so t < 2·`d_q` and one conditional subtract always suffices. No overflow is possible at DIV_W+1 bits.
  - `cnt` increments. On the edge that processes bit 0 (`cnt` = WIDTH−1), go to DONE and load the outputs:
    - `REM` ← final residue.
    - `DIVISIBLE` ← (final residue == 0).
    - `ERR` ← 0.
- DONE lasts exactly one cycle (`DONE`=1), then goes to IDLE unless a new START is accepted, which gives back-to-back operation.
- `DIVISIBLE`, `REM` and `ERR` are registered. They hold their last values through IDLE and through a following RUN, and change only on entry to DONE.
- Boundary values:
  - `A` = 0 gives `DIVISIBLE`=1, `REM`=0.
  - `DIV` = 1 gives `DIVISIBLE`=1, `REM`=0.
  - `DIV` > `A` gives `REM` = `A`, `DIVISIBLE` = (`A` == 0).

## Timing
- Reset, asynchronous: state=IDLE; `BUSY`, `DONE`, `DIVISIBLE`, `ERR` = 0; `REM` = 0; internal registers = 0. Effect is immediate; no clock is needed.
- Reset mid-RUN: the operation is abandoned and no DONE is issued. After RST deasserts, the block is idle and accepts START on the first rising edge.
- Latency, `DIV` ≠ 0: START accepted at edge E0. `BUSY`=1 after E0 through E(WIDTH−1). `DONE`=1 after E(WIDTH), for one cycle.
- Latency, `DIV` = 0: `DONE`=1 after E0+1 edge, i.e. the cycle right after acceptance; `BUSY` never rises.
- Throughput: with START held high, a new operation is accepted on the DONE cycle. One result every WIDTH+1 cycles.
- `A` and `DIV` may change freely after the accepting edge.

## Test plan
- WIDTH=5, DIV_W=4, A=27, DIV=9 → exactly 5 cycles after the START edge: `DONE` pulse with `DIVISIBLE`=1, `REM`=0, `ERR`=0. `BUSY` high for 5 cycles.
- A=31, DIV=7 → `REM`=3, `DIVISIBLE`=0. Then A=0, DIV=5 → `REM`=0, `DIVISIBLE`=1. Then A=4, DIV=9 → `REM`=4, `DIVISIBLE`=0.
- DIV=0, A=12 → `DONE` on the next cycle, `ERR`=1, `DIVISIBLE`=0, `REM`=0, `BUSY` never high. A following A=12, DIV=1 → `ERR`=0, `DIVISIBLE`=1.
- Pulse START again mid-RUN with different operands → ignored; the original result is produced on schedule. START held high across DONE → second operation starts with no idle cycle.
- Assert RST at cycle 2 of RUN → all outputs 0 immediately; no `DONE` pulse. A fresh START after release completes correctly.
- Exhaustive sweep at WIDTH=5, DIV_W=4 (all A 0..31, DIV 1..15), plus a random sweep at WIDTH=12, DIV_W=6 → `REM` == A mod DIV and `DIVISIBLE` == (A mod DIV == 0) for every case.

Source files
------------

// File: rtl/div_check_serial.sv
// Bit-serial divisibility checker: MSB-first restoring remainder of A mod DIV,
// one dividend bit per clock, with a START/BUSY/DONE handshake and divide-by-zero flag.
module div_check_serial #(
    parameter int WIDTH = 5,
    parameter int DIV_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [DIV_W-1:0] DIV,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIVISIBLE,
    output logic [DIV_W-1:0] REM,
    output logic             ERR
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q;
    logic [DIV_W-1:0] d_q, r_q, r_nx;
    logic [CW-1:0]    cnt;
    logic [DIV_W:0]   t, diff;
    logic             accept, last, dz;

    assign accept = START && (state != S_RUN);
    assign dz     = (DIV == '0);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign BUSY   = (state == S_RUN);
    assign DONE   = (state == S_DONE);

    // a_q shifts left each step, so its MSB is always the next dividend bit to consume.
    always_comb begin
        t    = {r_q, a_q[WIDTH-1]};
        diff = t - {1'b0, d_q};
        r_nx = (t >= {1'b0, d_q}) ? diff[DIV_W-1:0] : t[DIV_W-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) state_nx = dz ? S_DONE : S_RUN;
                else       state_nx = S_IDLE;
            end
            S_RUN:   if (last) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            cnt       <= '0;
            REM       <= '0;
            DIVISIBLE <= 1'b0;
            ERR       <= 1'b0;
        end else if (accept) begin
            a_q <= A;
            d_q <= DIV;
            r_q <= '0;
            cnt <= '0;
            // Zero divisor skips the run and publishes the error result straight away.
            if (dz) begin
                REM       <= '0;
                DIVISIBLE <= 1'b0;
                ERR       <= 1'b1;
            end
        end else if (state == S_RUN) begin
            a_q <= a_q << 1;
            r_q <= r_nx;
            cnt <= cnt + CW'(1);
            if (last) begin
                REM       <= r_nx;
                DIVISIBLE <= (r_nx == '0);
                ERR       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_check_serial.sv
// Scoreboard bench for div_check_serial: directed handshake/boundary scenarios at
// WIDTH=5/DIV_W=4 plus exhaustive and random remainder sweeps.
module tb_div_check_serial;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        start5 = 1'b0;
    logic [4:0]  a5 = '0;
    logic [3:0]  div5 = '0;
    logic        busy5, done5, dvs5, err5;
    logic [3:0]  rem5;

    logic        start12 = 1'b0;
    logic [11:0] a12 = '0;
    logic [5:0]  div12 = '0;
    logic        busy12, done12, dvs12, err12;
    logic [5:0]  rem12;

    int errors = 0;
    int checks = 0;

    typedef struct packed {logic dvs; logic [3:0] rem; logic err;} exp5_t;
    typedef struct packed {logic dvs; logic [5:0] rem;} exp12_t;
    exp5_t  q5[$];
    exp12_t q12[$];

    div_check_serial #(.WIDTH(5), .DIV_W(4)) dut5 (
        .CLK(CLK), .RST(RST), .START(start5), .A(a5), .DIV(div5),
        .BUSY(busy5), .DONE(done5), .DIVISIBLE(dvs5), .REM(rem5), .ERR(err5)
    );

    div_check_serial #(.WIDTH(12), .DIV_W(6)) dut12 (
        .CLK(CLK), .RST(RST), .START(start12), .A(a12), .DIV(div12),
        .BUSY(busy12), .DONE(done12), .DIVISIBLE(dvs12), .REM(rem12), .ERR(err12)
    );

    always #5 CLK = ~CLK;

    function automatic exp5_t model5(int a, int d);
        exp5_t e;
        int r;
        if (d == 0) begin
            e.dvs = 1'b0; e.rem = '0; e.err = 1'b1;
        end else begin
            r = a % d;
            e.dvs = (r == 0); e.rem = r[3:0]; e.err = 1'b0;
        end
        return e;
    endfunction

    // Drive operands and record the expected outcome.
    task automatic push5(int a, int d);
        a5   = a[4:0];
        div5 = d[3:0];
        q5.push_back(model5(a, d));
    endtask

    // Called just after the accepting edge; cyc = cycles until DONE is seen.
    task automatic wait_done5(output int cyc, output int bcnt, output bit to);
        cyc = 0; bcnt = 0; to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (done5) begin cyc = i; to = 1'b0; break; end
            if (busy5) bcnt++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_done12(output int cyc, output bit to);
        cyc = 0; to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (done12) begin cyc = i; to = 1'b0; break; end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy5, done5, dvs5, err5, rem5} !== 8'b0) begin
            errors++;
            $display("FAIL reset5 got busy=%0b done=%0b dvs=%0b err=%0b rem=%0d exp all 0",
                     busy5, done5, dvs5, err5, rem5);
        end
        checks++;
        if ({busy12, done12, dvs12, err12, rem12} !== 10'b0) begin
            errors++;
            $display("FAIL reset12 got busy=%0b done=%0b dvs=%0b err=%0b rem=%0d exp all 0",
                     busy12, done12, dvs12, err12, rem12);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_basic;
        int cyc, bc;
        bit to;
        exp5_t e, prev;
        int ta[4] = '{27, 31, 0, 4};
        int td[4] = '{9, 7, 5, 9};
        prev = '0;
        for (int k = 0; k < 4; k++) begin
            start5 = 1'b1; push5(ta[k], td[k]);
            @(posedge CLK); #1;
            start5 = 1'b0;
            checks++;
            if ({dvs5, rem5, err5} !== prev) begin
                errors++;
                $display("FAIL hold_in_run k=%0d got %b exp %b", k, {dvs5, rem5, err5}, prev);
            end
            wait_done5(cyc, bc, to);
            checks++;
            if (to || cyc != 5) begin
                errors++;
                $display("FAIL latency k=%0d got cyc=%0d timeout=%0b exp cyc=5", k, cyc, to);
            end
            checks++;
            if (bc != 5) begin
                errors++;
                $display("FAIL busy_len k=%0d got %0d exp 5", k, bc);
            end
            e = q5.pop_front();
            checks++;
            if ({dvs5, rem5, err5} !== {e.dvs, e.rem, e.err}) begin
                errors++;
                $display("FAIL result k=%0d got dvs=%0b rem=%0d err=%0b exp dvs=%0b rem=%0d err=%0b",
                         k, dvs5, rem5, err5, e.dvs, e.rem, e.err);
            end
            @(posedge CLK); #1;
            checks++;
            if (done5 !== 1'b0 || {dvs5, rem5, err5} !== e) begin
                errors++;
                $display("FAIL done_pulse_hold k=%0d got done=%0b res=%b exp done=0 res=%b",
                         k, done5, {dvs5, rem5, err5}, e);
            end
            prev = e;
        end
    endtask

    task automatic test_div_zero;
        int cyc, bc;
        bit to;
        exp5_t e;
        start5 = 1'b1; push5(12, 0);
        @(posedge CLK); #1;
        start5 = 1'b0;
        wait_done5(cyc, bc, to);
        checks++;
        if (to || cyc != 0 || bc != 0) begin
            errors++;
            $display("FAIL divzero_timing got cyc=%0d busy=%0d timeout=%0b exp cyc=0 busy=0", cyc, bc, to);
        end
        e = q5.pop_front();
        checks++;
        if ({dvs5, rem5, err5} !== {e.dvs, e.rem, e.err}) begin
            errors++;
            $display("FAIL divzero_result got dvs=%0b rem=%0d err=%0b exp dvs=%0b rem=%0d err=%0b",
                     dvs5, rem5, err5, e.dvs, e.rem, e.err);
        end
        @(posedge CLK); #1;
        checks++;
        if (busy5 !== 1'b0 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL divzero_after got busy=%0b done=%0b exp 0 0", busy5, done5);
        end
        start5 = 1'b1; push5(12, 1);
        @(posedge CLK); #1;
        start5 = 1'b0;
        wait_done5(cyc, bc, to);
        e = q5.pop_front();
        checks++;
        if (to || {dvs5, rem5, err5} !== {e.dvs, e.rem, e.err}) begin
            errors++;
            $display("FAIL div1_result got dvs=%0b rem=%0d err=%0b timeout=%0b exp dvs=%0b rem=%0d err=%0b",
                     dvs5, rem5, err5, to, e.dvs, e.rem, e.err);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_ignore_start;
        int cyc, bc;
        bit to;
        exp5_t e;
        start5 = 1'b1; push5(31, 7);
        @(posedge CLK); #1;
        start5 = 1'b0;
        @(posedge CLK); #1;
        start5 = 1'b1; a5 = 5'd27; div5 = 4'd9;
        @(posedge CLK); #1;
        start5 = 1'b0;
        wait_done5(cyc, bc, to);
        checks++;
        if (to || cyc + 2 != 5 || bc + 2 != 5) begin
            errors++;
            $display("FAIL ignore_timing got cyc=%0d busy=%0d timeout=%0b exp 5 5", cyc + 2, bc + 2, to);
        end
        e = q5.pop_front();
        checks++;
        if ({dvs5, rem5, err5} !== {e.dvs, e.rem, e.err}) begin
            errors++;
            $display("FAIL ignore_result got dvs=%0b rem=%0d err=%0b exp dvs=%0b rem=%0d err=%0b",
                     dvs5, rem5, err5, e.dvs, e.rem, e.err);
        end
        @(posedge CLK); #1;
        checks++;
        if (busy5 !== 1'b0 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart got busy=%0b done=%0b exp 0 0", busy5, done5);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        bit to;
        exp5_t e;
        start5 = 1'b1; push5(27, 9);
        @(posedge CLK); #1;
        wait_done5(cyc, bc, to);
        e = q5.pop_front();
        checks++;
        if (to || cyc != 5 || {dvs5, rem5, err5} !== {e.dvs, e.rem, e.err}) begin
            errors++;
            $display("FAIL b2b_first got cyc=%0d res=%b timeout=%0b exp cyc=5 res=%b",
                     cyc, {dvs5, rem5, err5}, to, e);
        end
        push5(31, 7);
        @(posedge CLK); #1;
        start5 = 1'b0;
        checks++;
        if (busy5 !== 1'b1 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle got busy=%0b done=%0b exp 1 0", busy5, done5);
        end
        wait_done5(cyc, bc, to);
        e = q5.pop_front();
        checks++;
        if (to || cyc != 5 || {dvs5, rem5, err5} !== {e.dvs, e.rem, e.err}) begin
            errors++;
            $display("FAIL b2b_second got cyc=%0d res=%b timeout=%0b exp cyc=5 res=%b",
                     cyc, {dvs5, rem5, err5}, to, e);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_run;
        int cyc, bc, seen;
        bit to;
        exp5_t e;
        start5 = 1'b1; push5(30, 7);
        @(posedge CLK); #1;
        start5 = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        void'(q5.pop_back());
        checks++;
        if ({busy5, done5, dvs5, err5, rem5} !== 8'b0) begin
            errors++;
            $display("FAIL reset_mid_run got busy=%0b done=%0b dvs=%0b err=%0b rem=%0d exp all 0",
                     busy5, done5, dvs5, err5, rem5);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done5 || busy5) seen++;
            @(posedge CLK); #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_done got active_cycles=%0d exp 0", seen);
        end
        start5 = 1'b1; push5(12, 5);
        @(posedge CLK); #1;
        start5 = 1'b0;
        wait_done5(cyc, bc, to);
        e = q5.pop_front();
        checks++;
        if (to || cyc != 5 || {dvs5, rem5, err5} !== {e.dvs, e.rem, e.err}) begin
            errors++;
            $display("FAIL reset_recover got cyc=%0d res=%b timeout=%0b exp cyc=5 res=%b",
                     cyc, {dvs5, rem5, err5}, to, e);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_sweep5;
        int cyc, bc;
        bit to;
        exp5_t e;
        for (int a = 0; a < 32; a++) begin
            for (int d = 1; d < 16; d++) begin
                start5 = 1'b1; push5(a, d);
                @(posedge CLK); #1;
                start5 = 1'b0;
                wait_done5(cyc, bc, to);
                e = q5.pop_front();
                checks++;
                if (to || {dvs5, rem5, err5} !== {e.dvs, e.rem, e.err}) begin
                    errors++;
                    $display("FAIL sweep5 a=%0d d=%0d got dvs=%0b rem=%0d err=%0b timeout=%0b exp dvs=%0b rem=%0d",
                             a, d, dvs5, rem5, err5, to, e.dvs, e.rem);
                end
            end
        end
    endtask

    task automatic test_sweep12;
        int cyc, a, d, r;
        bit to;
        exp12_t e;
        for (int k = 0; k < 150; k++) begin
            a = (k == 0) ? 4095 : int'($urandom_range(0, 4095));
            d = (k == 0) ? 63 : int'($urandom_range(1, 63));
            r = a % d;
            a12 = a[11:0]; div12 = d[5:0];
            e.dvs = (r == 0); e.rem = r[5:0];
            q12.push_back(e);
            start12 = 1'b1;
            @(posedge CLK); #1;
            start12 = 1'b0;
            wait_done12(cyc, to);
            e = q12.pop_front();
            checks++;
            if (to || cyc != 12 || {dvs12, rem12, err12} !== {e.dvs, e.rem, 1'b0}) begin
                errors++;
                $display("FAIL sweep12 a=%0d d=%0d got cyc=%0d dvs=%0b rem=%0d err=%0b timeout=%0b exp cyc=12 dvs=%0b rem=%0d",
                         a, d, cyc, dvs12, rem12, err12, to, e.dvs, e.rem);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid_run;
        test_sweep5;
        test_sweep12;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
